// File: rtl/sd_input_ctrl.sv
// Sigma-delta channel input control: synchronises modulator data/clock pins, selects the
// sampling event per mode, strobes one bit per sample and watchdogs the modulator clock.
module sd_input_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int WDT_LIMIT   = 255,
  parameter int WDT_W       = 8
) (
  input  logic       SYSCLK,
  input  logic       SYSRSTn,
  input  logic       DSDIN,
  input  logic       SDCLK,
  input  logic       icu_en,
  input  logic [1:0] icu_mod_reg,
  input  logic [3:0] icu_div_reg,
  output logic       sd_bit,
  output logic       sd_valid,
  output logic       clk_err,
  output logic       icu_err_signal
);

  localparam logic [1:0] MOD_RISE = 2'd0;
  localparam logic [1:0] MOD_BOTH = 2'd1;
  localparam logic [1:0] MOD_FALL = 2'd2;
  localparam logic [1:0] MOD_DIV  = 2'd3;

  localparam logic [WDT_W-1:0] WDT_MAX = WDT_W'(WDT_LIMIT);

  logic [SYNC_STAGES-1:0] d_sync;
  logic [SYNC_STAGES-1:0] c_sync;
  logic                   c_h;
  logic [1:0]             mod_q;
  logic [3:0]             div_cnt;
  logic [WDT_W-1:0]       wdt_cnt;

  logic       d_s;
  logic       c_s;
  logic       rise;
  logic       fall;
  logic       valid_ev;
  logic       mod_chg;
  logic [WDT_W-1:0] wdt_nxt;

  assign d_s     = d_sync[SYNC_STAGES-1];
  assign c_s     = c_sync[SYNC_STAGES-1];
  assign rise    = c_s & ~c_h;
  assign fall    = ~c_s & c_h;
  assign mod_chg = (icu_mod_reg != mod_q);
  assign wdt_nxt = wdt_cnt + WDT_W'(1);

  always_comb begin
    valid_ev = 1'b0;
    case (icu_mod_reg)
      MOD_RISE: valid_ev = rise;
      MOD_BOTH: valid_ev = rise | fall;
      MOD_FALL: valid_ev = fall;
      default:  valid_ev = 1'b0;
    endcase
  end

  // Synchronisers and edge history run regardless of enable so that a re-enable never
  // sees a stale edge.
  always_ff @(posedge SYSCLK or negedge SYSRSTn) begin
    if (!SYSRSTn) begin
      d_sync <= '0;
      c_sync <= '0;
      c_h    <= 1'b0;
      mod_q  <= 2'd0;
    end else begin
      d_sync <= {d_sync[SYNC_STAGES-2:0], DSDIN};
      c_sync <= {c_sync[SYNC_STAGES-2:0], SDCLK};
      c_h    <= c_s;
      mod_q  <= icu_mod_reg;
    end
  end

  always_ff @(posedge SYSCLK or negedge SYSRSTn) begin
    if (!SYSRSTn) begin
      sd_bit         <= 1'b0;
      sd_valid       <= 1'b0;
      clk_err        <= 1'b0;
      icu_err_signal <= 1'b0;
      div_cnt        <= 4'd0;
      wdt_cnt        <= '0;
    end else if (!icu_en || mod_chg) begin
      sd_valid       <= 1'b0;
      clk_err        <= 1'b0;
      icu_err_signal <= 1'b0;
      div_cnt        <= 4'd0;
      wdt_cnt        <= '0;
    end else if (icu_mod_reg == MOD_DIV) begin
      clk_err        <= 1'b0;
      icu_err_signal <= 1'b0;
      wdt_cnt        <= '0;
      if (div_cnt == icu_div_reg) begin
        div_cnt  <= 4'd0;
        sd_valid <= 1'b1;
        sd_bit   <= d_s;
      end else if (div_cnt > icu_div_reg) begin
        // divide ratio lowered under the running count: restart without a strobe
        div_cnt  <= 4'd0;
        sd_valid <= 1'b0;
      end else begin
        div_cnt  <= div_cnt + 4'd1;
        sd_valid <= 1'b0;
      end
    end else begin
      div_cnt <= 4'd0;
      if (valid_ev) begin
        sd_valid       <= 1'b1;
        sd_bit         <= d_s;
        wdt_cnt        <= '0;
        clk_err        <= 1'b0;
        icu_err_signal <= 1'b0;
      end else begin
        sd_valid <= 1'b0;
        if (wdt_cnt != WDT_MAX) begin
          wdt_cnt <= wdt_nxt;
          if (wdt_nxt == WDT_MAX) begin
            clk_err        <= 1'b1;
            icu_err_signal <= 1'b1;
          end else begin
            icu_err_signal <= 1'b0;
          end
        end else begin
          icu_err_signal <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sd_input_ctrl.sv
// Bench for sd_input_ctrl: directed and random pin stimulus, checked every cycle against
// a pin-history reference model of the sampling, divider and watchdog rules.
module tb_sd_input_ctrl;

  logic       SYSCLK = 1'b0;
  logic       SYSRSTn = 1'b0;
  logic       DSDIN = 1'b0;
  logic       SDCLK = 1'b0;
  logic       icu_en = 1'b0;
  logic [1:0] icu_mod_reg = 2'd0;
  logic [3:0] icu_div_reg = 4'd0;
  logic       sd_bit;
  logic       sd_valid;
  logic       clk_err;
  logic       icu_err_signal;

  sd_input_ctrl #(.SYNC_STAGES(2), .WDT_LIMIT(255), .WDT_W(8)) dut (
    .SYSCLK(SYSCLK), .SYSRSTn(SYSRSTn), .DSDIN(DSDIN), .SDCLK(SDCLK),
    .icu_en(icu_en), .icu_mod_reg(icu_mod_reg), .icu_div_reg(icu_div_reg),
    .sd_bit(sd_bit), .sd_valid(sd_valid), .clk_err(clk_err),
    .icu_err_signal(icu_err_signal)
  );

  always #5 SYSCLK = ~SYSCLK;

  localparam int LIMIT = 255;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;

  // pin/config values as sampled at each SYSCLK edge since the last reset release
  bit cp_q[$];
  bit dp_q[$];
  bit en_q[$];
  int md_q[$];
  int dv_q[$];

  int run_len = 0;   // consecutive watchdog-counting cycles
  int m3n = 0;       // cycles since divided-strobe mode became active
  bit exp_bit = 1'b0;
  bit exp_valid, exp_err, exp_clk;
  int pulse_cnt = 0;

  function automatic bit cp_at(input int i);
    return (i < 0) ? 1'b0 : cp_q[i];
  endfunction

  function automatic bit dp_at(input int i);
    return (i < 0) ? 1'b0 : dp_q[i];
  endfunction

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One SYSCLK cycle: inputs were driven at the preceding negedge.
  task automatic step();
    int e, m, pm;
    bit chg, c2, c3, d2, rise, fall, ev;
    @(posedge SYSCLK);
    cp_q.push_back(SDCLK);
    dp_q.push_back(DSDIN);
    en_q.push_back(icu_en);
    md_q.push_back(int'(icu_mod_reg));
    dv_q.push_back(int'(icu_div_reg));
    #1;
    e   = cp_q.size() - 1;
    m   = md_q[e];
    pm  = (e > 0) ? md_q[e-1] : 0;
    chg = (m != pm);
    // a pin level captured at edge k is acted on at edge k+2
    c2 = cp_at(e-2);
    c3 = cp_at(e-3);
    d2 = dp_at(e-2);
    rise = c2 && !c3;
    fall = !c2 && c3;
    ev = (m == 0 && rise) || (m == 1 && (rise || fall)) || (m == 2 && fall);
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    if (!en_q[e] || chg) begin
      run_len = 0;
      m3n = 0;
    end else if (m == 3) begin
      run_len = 0;
      m3n++;
      if (m3n % (dv_q[e] + 1) == 0) begin
        exp_valid = 1'b1;
        exp_bit = d2;
      end
    end else begin
      m3n = 0;
      if (ev) begin
        run_len = 0;
        exp_valid = 1'b1;
        exp_bit = d2;
      end else if (run_len < LIMIT) begin
        run_len++;
        if (run_len == LIMIT) exp_err = 1'b1;
      end
    end
    exp_clk = (run_len >= LIMIT);
    check_bit("sd_valid", sd_valid, exp_valid);
    check_bit("sd_bit", sd_bit, exp_bit);
    check_bit("clk_err", clk_err, exp_clk);
    check_bit("icu_err_signal", icu_err_signal, exp_err);
    if (icu_err_signal === 1'b1) pulse_cnt++;
    cyc++;
    @(negedge SYSCLK);
  endtask

  // Reset asserted shortly after an active edge; outputs must clear without waiting for a clock.
  task automatic do_reset();
    @(posedge SYSCLK);
    #2;
    SYSRSTn = 1'b0;
    #1;
    check_bit("rst_sd_valid", sd_valid, 1'b0);
    check_bit("rst_sd_bit", sd_bit, 1'b0);
    check_bit("rst_clk_err", clk_err, 1'b0);
    check_bit("rst_err_signal", icu_err_signal, 1'b0);
    repeat (2) @(negedge SYSCLK);
    SYSRSTn = 1'b1;
    cp_q.delete();
    dp_q.delete();
    en_q.delete();
    md_q.delete();
    dv_q.delete();
    run_len = 0;
    m3n = 0;
    exp_bit = 1'b0;
  endtask

  // n modulator periods, 'half' SYSCLK cycles per level, DSDIN toggled on each fall
  task automatic sd_periods(input int n, input int half);
    for (int p = 0; p < n; p++) begin
      SDCLK = 1'b1;
      repeat (half) step();
      SDCLK = 1'b0;
      DSDIN = ~DSDIN;
      repeat (half) step();
    end
  endtask

  initial begin
    int lat;
    int strobes;
    do_reset();

    // mode 0, SDCLK = SYSCLK/8
    icu_en = 1'b1;
    icu_mod_reg = 2'd0;
    DSDIN = 1'b1;
    repeat (4) step();
    sd_periods(6, 4);

    // explicit rise-to-strobe latency
    SDCLK = 1'b1;
    lat = 0;
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      step();
      if (sd_valid === 1'b1) lat = i;
    end
    check_int("rise_latency", lat, 3);
    repeat (3) step();
    SDCLK = 1'b0;
    repeat (4) step();

    // mode 1: two strobes per period
    icu_mod_reg = 2'd1;
    strobes = 0;
    for (int i = 0; i < 4; i++) step();
    for (int p = 0; p < 4; p++) begin
      SDCLK = 1'b1;
      for (int i = 0; i < 4; i++) begin step(); if (sd_valid === 1'b1) strobes++; end
      SDCLK = 1'b0;
      DSDIN = ~DSDIN;
      for (int i = 0; i < 4; i++) begin step(); if (sd_valid === 1'b1) strobes++; end
    end
    check_int("both_edge_strobes", strobes, 8);

    // mode 2: strobes on falls only
    icu_mod_reg = 2'd2;
    repeat (4) step();
    sd_periods(5, 4);

    // mode 3, div 3 then div 0, SDCLK idle
    icu_mod_reg = 2'd3;
    icu_div_reg = 4'd3;
    SDCLK = 1'b0;
    for (int i = 0; i < 40; i++) begin
      DSDIN = 1'($urandom);
      step();
    end
    icu_en = 1'b0;
    icu_div_reg = 4'd0;
    step();
    icu_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      DSDIN = 1'($urandom);
      step();
    end

    // mode 0 watchdog: stall, single error pulse, recovery on first rise
    icu_mod_reg = 2'd0;
    pulse_cnt = 0;
    sd_periods(3, 4);
    repeat (300) step();
    check_bit("clk_err_stalled", clk_err, 1'b1);
    sd_periods(3, 3);
    check_int("err_pulses", pulse_cnt, 1);

    // mode switch 0 -> 2 mid-stream, enable toggles
    sd_periods(2, 4);
    SDCLK = 1'b1;
    repeat (2) step();
    icu_mod_reg = 2'd2;
    repeat (2) step();
    sd_periods(2, 4);
    icu_en = 1'b0;
    SDCLK = 1'b1;
    repeat (3) step();
    SDCLK = 1'b0;
    repeat (3) step();
    icu_en = 1'b1;
    sd_periods(2, 3);

    // random pins, modes, enables, duty cycles
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0) SDCLK = ~SDCLK;
      DSDIN = 1'($urandom);
      if ($urandom_range(0, 59) == 0) icu_mod_reg = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 79) == 0) icu_en = ~icu_en;
      step();
    end
    icu_en = 1'b1;

    // reset in the middle of a stream, then resume
    icu_mod_reg = 2'd1;
    sd_periods(2, 2);
    SDCLK = 1'b1;
    do_reset();
    sd_periods(3, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
